// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute/memory/write-back sequencer
module cpu_sequencer #(
    parameter logic [3:0] HALT_OPCODE = 4'hF,
    parameter int         TIMEOUT     = 15,
    parameter int         COUNT_W     = 24
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Run,
    input  logic [3:0]         Opcode,
    input  logic               Jump,
    input  logic               Branch,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               RegWrite,
    input  logic               MemReady,
    output logic               MemReq,
    output logic               MemWe,
    output logic               InstrFetch,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               RegWriteEn,
    output logic               Halted,
    output logic               Fault,
    output logic [2:0]         State,
    output logic [COUNT_W-1:0] InstrCount
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    // Miss count at which the next miss is the TIMEOUT-th one.
    localparam logic [3:0] WAIT_LAST = 4'(TIMEOUT - 1);

    state_t               state_q, state_d;
    logic [3:0]           wait_q, wait_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic                 retire;

    // Jump and Branch only describe the no-memory EXEC path, which needs no
    // further distinction here; branch selection lives in the datapath.
    logic unused_ctrl;
    assign unused_ctrl = Jump ^ Branch;

    // State, wait counter and retired-instruction counter registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            wait_q  <= 4'd0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Next-state selection plus the per-state datapath enables.
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        count_d    = count_q;
        retire     = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegWriteEn = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (MemReady) begin
                    IRWrite = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                if (Opcode == HALT_OPCODE) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (MemRead && MemWrite) begin
                    state_d = S_FAULT;
                end else if (MemRead || MemWrite) begin
                    state_d = S_MEM;
                end else if (RegWrite) begin
                    state_d = S_WB;
                end else begin
                    PCWrite = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                if (MemReady) begin
                    if (MemRead && RegWrite) begin
                        state_d = S_WB;
                    end else begin
                        PCWrite = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WB: begin
                RegWriteEn = 1'b1;
                PCWrite    = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                // Resuming steps the PC past the halt instruction.
                if (Run) begin
                    PCWrite = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase

        // Any state change restarts the wait count, so each FETCH/MEM entry
        // begins its timeout window from zero.
        if (state_d != state_q) wait_d = 4'd0;

        if (retire) count_d = count_q + COUNT_W'(1);
    end

    // Moore-decoded memory port controls and status flags.
    always_comb begin
        MemReq     = (state_q == S_FETCH) || (state_q == S_MEM);
        MemWe      = (state_q == S_MEM) && MemWrite;
        InstrFetch = (state_q == S_FETCH);
        Halted     = (state_q == S_HALT);
        Fault      = (state_q == S_FAULT);
    end

    assign State      = state_q;
    assign InstrCount = count_q;

endmodule
